// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store unit: valid/ready data bus, pipeline stall,
//            load lane extraction/extension and MEM/WB register.
//            Optional misaligned-access trap enabled by macro MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REG_W_En_M,
  input  logic        MEM_W_En_M,
  input  logic [2:0]  MEM_Control_M,
  input  logic [1:0]  Result_Src_Sel_M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] REG_R_Data2_M,
  input  logic [31:0] ALU_Out_M,
  input  logic [31:0] PC_Plus_4_M,
  output logic        Stall_M,
  output logic        DMEM_Req,
  output logic        DMEM_We,
  output logic [31:0] DMEM_Addr,
  output logic [31:0] DMEM_WData,
  output logic [3:0]  DMEM_Byte_En,
  input  logic        DMEM_Ready,
  input  logic [31:0] DMEM_RData,
  output logic        REG_W_En_W,
  output logic [1:0]  Result_Src_Sel_W,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_Out_W,
  output logic [31:0] PC_Plus_4_W,
  output logic [31:0] Load_Data_W,
  output logic [1:0]  Fault_W
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] c_sz_b = 2'd0;
  localparam logic [1:0] c_sz_h = 2'd1;
  localparam logic [1:0] c_sz_w = 2'd2;

  state_t      r_state;
  logic [7:0]  r_count;

  logic        w_is_load;
  logic        w_access;
  logic        w_trap;
  logic        w_timeout;
  logic        w_capture;
  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic [1:0]  w_fault;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;
  logic [31:0] w_load_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_is_load = (Result_Src_Sel_M == 2'b01);
  assign w_access  = MEM_W_En_M | w_is_load;

  always_comb begin
    case (MEM_Control_M)
      3'b000, 3'b100: w_size = c_sz_b;
      3'b001, 3'b101: w_size = c_sz_h;
      default:        w_size = c_sz_w;
    endcase
  end

  // Lane offset with the bits below the access size dropped
  always_comb begin
    w_off = ALU_Out_M[1:0];
    if (w_size == c_sz_h)      w_off[0] = 1'b0;
    else if (w_size == c_sz_w) w_off    = 2'b00;
  end

`ifdef MISALIGN_TRAP_EN
  assign w_trap = w_access & (w_off != ALU_Out_M[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    case (w_size)
      c_sz_b: begin
        w_byte_en = 4'b0001 << w_off;
        w_wdata   = {4{REG_R_Data2_M[7:0]}};
      end
      c_sz_h: begin
        w_byte_en = 4'b0011 << w_off;
        w_wdata   = {2{REG_R_Data2_M[15:0]}};
      end
      default: begin
        w_byte_en = 4'b1111;
        w_wdata   = REG_R_Data2_M;
      end
    endcase
  end

  assign w_byte = DMEM_RData[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? DMEM_RData[31:16] : DMEM_RData[15:0];

  always_comb begin
    case (w_size)
      c_sz_b:  w_load_fmt = MEM_Control_M[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      c_sz_h:  w_load_fmt = MEM_Control_M[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_fmt = DMEM_RData;
    endcase
  end

  assign w_timeout = (r_state == S_BUSY) & ~DMEM_Ready & (r_count == c_timeout_last);

  // Gated by RST_N so a held access cannot stall the pipe during reset
  assign Stall_M = RST_N & (((r_state == S_IDLE) & w_access & ~w_trap) |
                            ((r_state == S_BUSY) & ~DMEM_Ready & ~w_timeout));

  assign w_fault   = {w_timeout, (r_state == S_IDLE) & w_trap};
  assign w_capture = ~Stall_M;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state          <= S_IDLE;
      r_count          <= 8'd0;
      DMEM_Req         <= 1'b0;
      DMEM_We          <= 1'b0;
      DMEM_Addr        <= 32'd0;
      DMEM_WData       <= 32'd0;
      DMEM_Byte_En     <= 4'd0;
      REG_W_En_W       <= 1'b0;
      Result_Src_Sel_W <= 2'd0;
      RD_W             <= 5'd0;
      ALU_Out_W        <= 32'd0;
      PC_Plus_4_W      <= 32'd0;
      Load_Data_W      <= 32'd0;
      Fault_W          <= 2'd0;
    end else begin
      if (w_capture) begin
        REG_W_En_W       <= REG_W_En_M & (w_fault == 2'b00);
        Result_Src_Sel_W <= Result_Src_Sel_M;
        RD_W             <= RD_M;
        ALU_Out_W        <= ALU_Out_M;
        PC_Plus_4_W      <= PC_Plus_4_M;
        Load_Data_W      <= (w_is_load && (r_state == S_BUSY) && !w_timeout) ? w_load_fmt : 32'd0;
        Fault_W          <= w_fault;
      end
      case (r_state)
        S_IDLE: begin
          if (w_access && !w_trap) begin
            r_state      <= S_BUSY;
            r_count      <= 8'd0;
            DMEM_Req     <= 1'b1;
            DMEM_We      <= MEM_W_En_M;
            DMEM_Addr    <= {ALU_Out_M[31:2], 2'b00};
            DMEM_WData   <= w_wdata;
            DMEM_Byte_En <= w_byte_en;
          end
        end
        S_BUSY: begin
          if (DMEM_Ready || w_timeout) begin
            r_state  <= S_IDLE;
            DMEM_Req <= 1'b0;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
